rf_port_scheduler: RTL and testbench
====================================

# rf_port_scheduler

Shares the `register_block` ports among two writeback sources and one operand-read requester. The register file has a single `warp_selector` for both read and write, so the scheduler decides each cycle which warp owns the file, then drives the write port, both read ports and the selector. It sits between the issue/writeback stages and `register_block`, and guarantees that a read starved by cross-warp writes is eventually served.

## Interface
- `NUM_LANES`, 8, lanes per warp.
- `DATA_W`, 64, bits per lane register.
- `NUM_REGS`, 16, registers per lane; `AW = $clog2(NUM_REGS)`.
- `NUM_WARPS`, 8, warps; `WW = $clog2(NUM_WARPS)`.
- `STARVE_LIMIT`, 3, consecutive denied read cycles before the read is forced through.
- `clk  in  1`  clock, all state on rising edge.
- `rst  in  1`  reset, asynchronous, active-high.
- `wb{0,1}_valid  in  1`  writeback request.
- `wb{0,1}_ready  out  1`  request granted this cycle.
- `wb{0,1}_warp  in  WW`  target warp.
- `wb{0,1}_addr  in  AW`  target register.
- `wb{0,1}_mask  in  NUM_LANES`  lane write enables.
- `wb{0,1}_data  in  NUM_LANES*DATA_W`  lane data; lane i is in bits `[i*DATA_W +: DATA_W]`.
- `rd_valid  in  1`  operand-read request.
- `rd_ready  out  1`  read granted this cycle.
- `rd_warp  in  WW`  warp to read.
- `rd_en_0` / `rd_en_1`  `in  NUM_LANES`  per-port lane read enables.
- `rd_addr_0` / `rd_addr_1`  `in  AW`  per-port register address.
- `rd_data_0` / `rd_data_1`  `out  NUM_LANES*DATA_W`  returned operands, valid while `rd_ready`.
- `rf_warp_selector  out  WW`, `rf_write_en  out  NUM_LANES`, `rf_waddr  out  AW`, `rf_wdata  out  NUM_LANES*DATA_W`  register-file write side.
- `rf_read_en_0` / `rf_read_en_1`  `out  NUM_LANES`, `rf_raddr_0` / `rf_raddr_1`  `out  AW`  register-file read side.
- `rf_rdata_0` / `rf_rdata_1`  `in  NUM_LANES*DATA_W`  register-file read data, packed by lane.
- `starve_boost  out  1`  high when `starve_cnt == STARVE_LIMIT`.

## Operation
- **State**
  - `rr_ptr` (1b): preferred writeback source.
  - `starve_cnt` (`$clog2(STARVE_LIMIT+1)` bits).
- **Writeback winner W, chosen each cycle**
  - Both sources valid: source `rr_ptr` wins.
  - One source valid: that source wins.
- **Grant rules**, with R = `rd_valid`:
  - No W: grant R if present.
  - W, and no R: grant W.
  - W and R, same warp: grant both.
  - W and R, different warps, `starve_cnt == STARVE_LIMIT`: grant R only.
  - W and R, different warps, otherwise: grant W only.
- `rf_warp_selector`:
  - Granted write's warp if any.
  - Else `rd_warp` if the read is granted.
  - Else 0.
- All `rf_*` enables are zero for ungranted requests. `rf_*` addresses and data are muxed from the granted requester, otherwise 0.
- `rd_data_p` = `rf_rdata_p` (bypass merge described under Configuration).
- **Update on `clk`**
  - A write granted from source s sets `rr_ptr <= ~s`.
  - `starve_cnt` increments when R is denied; it clears when R is granted or `rd_valid` is 0.
- **Handshake**
  - A requester holds all of its fields stable while `valid && !ready`.
  - `ready` may depend combinationally on `valid`.
- A request with an all-zero mask or all-zero enables is still granted and consumed, with no lanes enabled.
- Reset: `rr_ptr = 0`, `starve_cnt = 0`.

## Timing
- Zero-cycle scheduling: grants and `rf_*` outputs are combinational from requests and state.
- A granted write commits at the rising edge that ends the grant cycle.
- Read data is returned in the grant cycle.
- During reset:
  - `wb*_ready`, `rd_ready`, `rf_write_en`, `rf_read_en_*` and `starve_boost` are 0.
  - Every other output is 0.
  - Requests are ignored.
- Worst-case read wait under continuous cross-warp writes: `STARVE_LIMIT` cycles; it is granted in cycle `STARVE_LIMIT+1`.
- Reset asserted mid-request: state clears and the in-flight request is re-arbitrated after release.

## Configuration
- `RF_BYPASS_EN` defined:
  - Applies when a same-warp write and read are both granted and `rf_waddr == rd_addr_p`.
  - For each lane with both write mask and `rd_en_p` set, `rd_data_p` takes the write data instead of `rf_rdata_p`.
- `RF_BYPASS_EN` undefined: `rd_data_p` always equals `rf_rdata_p`, which is the pre-write value.

## Structure
- Package `rf_sched_pkg`:
  - Default parameter constants.
  - `wb_req_t` struct (`warp`, `addr`, `mask`, `data`).
  - `rd_req_t` struct.
- Sub-module `rf_wb_rr_arbiter`: 2-way round-robin, holding `rr_ptr`; outputs winner index and valid.

## Test plan
- Reset release, no requests:
  - All `rf_*` outputs are 0.
  - `wb0` then valid (warp 2, addr 5, mask 8'hFF) → `wb0_ready=1`, `rf_warp_selector=2`, `rf_write_en=8'hFF`.
  - A read of warp 2, addr 5 in the next cycle returns the written data.
- Both wb valid for 4 cycles after reset, different warps:
  - Grants go wb0, wb1, wb0, wb1.
- Write warp 1 and read warp 1 in the same cycle, addr 3, masks 8'hFF:
  - Both granted.
  - Bypass on: `rd_data_0` equals the new data.
  - Bypass off: `rd_data_0` equals the old data.
- `wb0` continuously writing warp 0, read of warp 4 held:
  - Read is denied 3 cycles; `starve_boost=1` in cycle 4.
  - Read granted in cycle 4 with `wb0_ready=0`.
  - `starve_cnt` returns to 0 in cycle 5.
- Write mask 8'h0F, read enables 8'hFF on the same warp and address, bypass on:
  - Lanes 0–3 are forwarded.
  - Lanes 4–7 come from `rf_rdata`.
- `rst` asserted with `starve_cnt=2` → after release a cross-warp read needs 3 fresh denials before it is forced through.

Source files
------------

// File: rtl/rf_port_scheduler_pkg.sv
// Shared constants, request structs and the lane-merge helper for rf_port_scheduler.
// Define RF_BYPASS_EN to forward same-cycle write data into same-address reads.
package rf_sched_pkg;

  localparam int NUM_LANES    = 8;
  localparam int DATA_W       = 64;
  localparam int NUM_REGS     = 16;
  localparam int NUM_WARPS    = 8;
  localparam int STARVE_LIMIT = 3;

  localparam int AW = $clog2(NUM_REGS);
  localparam int WW = $clog2(NUM_WARPS);
  localparam int LW = NUM_LANES * DATA_W;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [WW-1:0]        warp;
    logic [AW-1:0]        addr;
    logic [NUM_LANES-1:0] mask;
    logic [LW-1:0]        data;
  } wb_req_t;

  typedef struct packed {
    logic [WW-1:0]        warp;
    logic [NUM_LANES-1:0] en_0;
    logic [NUM_LANES-1:0] en_1;
    logic [AW-1:0]        addr_0;
    logic [AW-1:0]        addr_1;
  } rd_req_t;

  // Lanes with sel set take alt, the rest keep base.
  function automatic logic [LW-1:0] lane_merge(input logic [LW-1:0]        base,
                                               input logic [LW-1:0]        alt,
                                               input logic [NUM_LANES-1:0] sel);
    logic [LW-1:0] r;
    r = base;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (sel[i]) r[i*DATA_W +: DATA_W] = alt[i*DATA_W +: DATA_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_port_scheduler_if.sv
// Request, register-file and debug signals of rf_port_scheduler.
// master = requesters plus register file, slave = the scheduler.
interface rf_port_scheduler_if;
  import rf_sched_pkg::*;

  // Handshake: a request is consumed in a cycle where valid && ready; while
  // valid && !ready the requester holds every field stable. ready may depend
  // combinationally on valid in the same cycle.
  logic                 wb0_valid, wb0_ready;
  logic [WW-1:0]        wb0_warp;
  logic [AW-1:0]        wb0_addr;
  logic [NUM_LANES-1:0] wb0_mask;
  logic [LW-1:0]        wb0_data;

  logic                 wb1_valid, wb1_ready;
  logic [WW-1:0]        wb1_warp;
  logic [AW-1:0]        wb1_addr;
  logic [NUM_LANES-1:0] wb1_mask;
  logic [LW-1:0]        wb1_data;

  logic                 rd_valid, rd_ready;
  logic [WW-1:0]        rd_warp;
  logic [NUM_LANES-1:0] rd_en_0, rd_en_1;
  logic [AW-1:0]        rd_addr_0, rd_addr_1;
  logic [LW-1:0]        rd_data_0, rd_data_1;

  logic [WW-1:0]        rf_warp_selector;
  logic [NUM_LANES-1:0] rf_write_en;
  logic [AW-1:0]        rf_waddr;
  logic [LW-1:0]        rf_wdata;
  logic [NUM_LANES-1:0] rf_read_en_0, rf_read_en_1;
  logic [AW-1:0]        rf_raddr_0, rf_raddr_1;
  logic [LW-1:0]        rf_rdata_0, rf_rdata_1;

  logic                 starve_boost;
  logic [SW-1:0]        starve_cnt;
  logic                 rr_ptr;

  modport master (
    output wb0_valid, wb0_warp, wb0_addr, wb0_mask, wb0_data,
    output wb1_valid, wb1_warp, wb1_addr, wb1_mask, wb1_data,
    output rd_valid, rd_warp, rd_en_0, rd_en_1, rd_addr_0, rd_addr_1,
    output rf_rdata_0, rf_rdata_1,
    input  wb0_ready, wb1_ready, rd_ready, rd_data_0, rd_data_1,
    input  rf_warp_selector, rf_write_en, rf_waddr, rf_wdata,
    input  rf_read_en_0, rf_read_en_1, rf_raddr_0, rf_raddr_1,
    input  starve_boost, starve_cnt, rr_ptr
  );

  modport slave (
    input  wb0_valid, wb0_warp, wb0_addr, wb0_mask, wb0_data,
    input  wb1_valid, wb1_warp, wb1_addr, wb1_mask, wb1_data,
    input  rd_valid, rd_warp, rd_en_0, rd_en_1, rd_addr_0, rd_addr_1,
    input  rf_rdata_0, rf_rdata_1,
    output wb0_ready, wb1_ready, rd_ready, rd_data_0, rd_data_1,
    output rf_warp_selector, rf_write_en, rf_waddr, rf_wdata,
    output rf_read_en_0, rf_read_en_1, rf_raddr_0, rf_raddr_1,
    output starve_boost, starve_cnt, rr_ptr
  );

endinterface

// File: rtl/rf_wb_rr_arbiter.sv
// Two-way round-robin pick between the writeback sources; rr_ptr names the
// source preferred on a tie and moves past whichever source was granted.
module rf_wb_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       win_idx,
  output logic       win_valid,
  output logic       rr_ptr
);

  assign win_valid = |req;
  assign win_idx   = (req == 2'b11) ? rr_ptr : req[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (grant_en) begin
      rr_ptr <= ~win_idx;
    end
  end

endmodule

// File: rtl/rf_port_scheduler.sv
// Decides each cycle which warp owns the single-selector register file and
// muxes writeback/read requests onto it. Optional forwarding: RF_BYPASS_EN.
module rf_port_scheduler
  import rf_sched_pkg::*;
(
  input logic               clk,
  input logic               rst,
  rf_port_scheduler_if.slave bus
);

  wb_req_t              wb_req_0, wb_req_1, win_req;
  rd_req_t              rd_req;
  logic                 wb0_v, wb1_v, rd_v;
  logic                 win_idx, win_valid, rr_ptr;
  logic                 same_warp, boost, grant_w, grant_r;
  logic [SW-1:0]        starve_cnt;
  logic [NUM_LANES-1:0] byp_0, byp_1;

  // Requests are invisible while reset is held.
  assign wb0_v = bus.wb0_valid && !rst;
  assign wb1_v = bus.wb1_valid && !rst;
  assign rd_v  = bus.rd_valid  && !rst;

  assign wb_req_0 = '{warp: bus.wb0_warp, addr: bus.wb0_addr, mask: bus.wb0_mask, data: bus.wb0_data};
  assign wb_req_1 = '{warp: bus.wb1_warp, addr: bus.wb1_addr, mask: bus.wb1_mask, data: bus.wb1_data};
  assign rd_req   = '{warp: bus.rd_warp, en_0: bus.rd_en_0, en_1: bus.rd_en_1,
                      addr_0: bus.rd_addr_0, addr_1: bus.rd_addr_1};

  rf_wb_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({wb1_v, wb0_v}),
    .grant_en  (grant_w),
    .win_idx   (win_idx),
    .win_valid (win_valid),
    .rr_ptr    (rr_ptr)
  );

  assign win_req   = win_idx ? wb_req_1 : wb_req_0;
  assign same_warp = (win_req.warp == rd_req.warp);
  assign boost     = !rst && (starve_cnt == SW'(STARVE_LIMIT));

  // A starved read pre-empts a cross-warp write; same-warp pairs share the file.
  assign grant_w = win_valid && (!rd_v || same_warp || !boost);
  assign grant_r = rd_v && (!win_valid || same_warp || boost);

  always_comb begin
    byp_0 = '0;
    byp_1 = '0;
`ifdef RF_BYPASS_EN
    if (grant_w && grant_r) begin
      if (win_req.addr == rd_req.addr_0) byp_0 = win_req.mask & rd_req.en_0;
      if (win_req.addr == rd_req.addr_1) byp_1 = win_req.mask & rd_req.en_1;
    end
`endif
  end

  always_comb begin
    bus.wb0_ready        = grant_w && !win_idx;
    bus.wb1_ready        = grant_w && win_idx;
    bus.rd_ready         = grant_r;
    bus.starve_boost     = boost;
    bus.starve_cnt       = starve_cnt;
    bus.rr_ptr           = rr_ptr;
    bus.rf_warp_selector = '0;
    bus.rf_write_en      = '0;
    bus.rf_waddr         = '0;
    bus.rf_wdata         = '0;
    bus.rf_read_en_0     = '0;
    bus.rf_read_en_1     = '0;
    bus.rf_raddr_0       = '0;
    bus.rf_raddr_1       = '0;
    bus.rd_data_0        = '0;
    bus.rd_data_1        = '0;
    if (grant_w) begin
      bus.rf_warp_selector = win_req.warp;
      bus.rf_write_en      = win_req.mask;
      bus.rf_waddr         = win_req.addr;
      bus.rf_wdata         = win_req.data;
    end else if (grant_r) begin
      bus.rf_warp_selector = rd_req.warp;
    end
    if (grant_r) begin
      bus.rf_read_en_0 = rd_req.en_0;
      bus.rf_read_en_1 = rd_req.en_1;
      bus.rf_raddr_0   = rd_req.addr_0;
      bus.rf_raddr_1   = rd_req.addr_1;
    end
    if (!rst) begin
      bus.rd_data_0 = lane_merge(bus.rf_rdata_0, win_req.data, byp_0);
      bus.rd_data_1 = lane_merge(bus.rf_rdata_1, win_req.data, byp_1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (rd_v && !grant_r) begin
      starve_cnt <= starve_cnt + SW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_rf_port_scheduler.sv
// Directed plus randomized bench for rf_port_scheduler with a behavioural
// register file and a rule-level reference of the grant policy.
module tb_rf_port_scheduler;
  import rf_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_port_scheduler_if bus ();

  rf_port_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- register-file environment ----------------
  logic [31:0]       seed;
  logic              init_mem;
  logic [DATA_W-1:0] rf_mem  [NUM_WARPS][NUM_REGS][NUM_LANES];
  logic [DATA_W-1:0] ref_mem [NUM_WARPS][NUM_REGS][NUM_LANES];

  function automatic logic [DATA_W-1:0] seed_val(input int w, input int r, input int l);
    return {seed, 8'(w), 8'(r), 16'(l)};
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int w = 0; w < NUM_WARPS; w++)
        for (int r = 0; r < NUM_REGS; r++)
          for (int l = 0; l < NUM_LANES; l++) rf_mem[w][r][l] <= seed_val(w, r, l);
    end else begin
      for (int l = 0; l < NUM_LANES; l++)
        if (bus.rf_write_en[l])
          rf_mem[bus.rf_warp_selector][bus.rf_waddr][l] <= bus.rf_wdata[l*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    bus.rf_rdata_0 = '0;
    bus.rf_rdata_1 = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (bus.rf_read_en_0[l])
        bus.rf_rdata_0[l*DATA_W +: DATA_W] = rf_mem[bus.rf_warp_selector][bus.rf_raddr_0][l];
      if (bus.rf_read_en_1[l])
        bus.rf_rdata_1[l*DATA_W +: DATA_W] = rf_mem[bus.rf_warp_selector][bus.rf_raddr_1][l];
    end
  end

  // ---------------- reference model ----------------
  int                   ref_rr, ref_starve, w_src;
  logic                 e_wb0_rdy, e_wb1_rdy, e_rd_rdy, e_boost, e_gw;
  logic [31:0]          e_cnt, e_rr, e_sel, e_waddr, e_raddr0, e_raddr1;
  logic [NUM_LANES-1:0] e_wen, e_ren0, e_ren1;
  logic [LW-1:0]        e_wdata, e_rd0, e_rd1;

  logic                 o_wb0_rdy, o_wb1_rdy, o_rd_rdy, o_boost;
  logic [31:0]          o_cnt;
  logic [LW-1:0]        o_rd0;

  function automatic logic [LW-1:0] ref_row(input int w, input int a);
    logic [LW-1:0] r;
    for (int l = 0; l < NUM_LANES; l++) r[l*DATA_W +: DATA_W] = ref_mem[w][a][l];
    return r;
  endfunction

  // Expected read result: old contents per enabled lane, write data where forwarded.
  function automatic logic [LW-1:0] exp_rd(input int w, input int a, input logic [NUM_LANES-1:0] en,
                                           input logic both, input int wa,
                                           input logic [NUM_LANES-1:0] wm, input logic [LW-1:0] wd);
    logic [LW-1:0] r;
    r = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (en[l]) begin
        r[l*DATA_W +: DATA_W] = ref_mem[w][a][l];
`ifdef RF_BYPASS_EN
        if (both && wa == a && wm[l]) r[l*DATA_W +: DATA_W] = wd[l*DATA_W +: DATA_W];
`endif
      end
    end
    return r;
  endfunction

  task automatic model_eval();
    logic has_w, rv, gw, gr;
    int ww, wa;
    logic [NUM_LANES-1:0] wm;
    logic [LW-1:0] wd;
    {e_wb0_rdy, e_wb1_rdy, e_rd_rdy, e_boost, e_gw} = '0;
    {e_sel, e_waddr, e_raddr0, e_raddr1, e_wen, e_ren0, e_ren1} = '0;
    e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    e_cnt = rst ? 0 : ref_starve;
    e_rr  = rst ? 0 : ref_rr;
    if (!rst) begin
      has_w = bus.wb0_valid || bus.wb1_valid;
      rv    = bus.rd_valid;
      w_src = (bus.wb0_valid && bus.wb1_valid) ? ref_rr : (bus.wb1_valid ? 1 : 0);
      ww = (w_src == 1) ? int'(bus.wb1_warp) : int'(bus.wb0_warp);
      wa = (w_src == 1) ? int'(bus.wb1_addr) : int'(bus.wb0_addr);
      wm = (w_src == 1) ? bus.wb1_mask : bus.wb0_mask;
      wd = (w_src == 1) ? bus.wb1_data : bus.wb0_data;
      e_boost = (ref_starve == STARVE_LIMIT);
      if (!has_w)                       begin gw = 0; gr = rv; end
      else if (!rv)                     begin gw = 1; gr = 0; end
      else if (ww == int'(bus.rd_warp)) begin gw = 1; gr = 1; end
      else if (e_boost)                 begin gw = 0; gr = 1; end
      else                              begin gw = 1; gr = 0; end
      e_gw = gw;
      e_wb0_rdy = gw && w_src == 0;
      e_wb1_rdy = gw && w_src == 1;
      e_rd_rdy  = gr;
      if (gw) begin
        e_sel = ww; e_wen = wm; e_waddr = wa; e_wdata = wd;
      end else if (gr) begin
        e_sel = bus.rd_warp;
      end
      if (gr) begin
        e_ren0 = bus.rd_en_0; e_ren1 = bus.rd_en_1;
        e_raddr0 = bus.rd_addr_0; e_raddr1 = bus.rd_addr_1;
        e_rd0 = exp_rd(bus.rd_warp, bus.rd_addr_0, bus.rd_en_0, gw, wa, wm, wd);
        e_rd1 = exp_rd(bus.rd_warp, bus.rd_addr_1, bus.rd_en_1, gw, wa, wm, wd);
      end
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      ref_rr = 0;
      ref_starve = 0;
    end else begin
      if (e_gw) begin
        ref_rr = 1 - w_src;
        for (int l = 0; l < NUM_LANES; l++)
          if (e_wen[l]) ref_mem[e_sel][e_waddr][l] = e_wdata[l*DATA_W +: DATA_W];
      end
      if (bus.rd_valid && !e_rd_rdy) ref_starve++;
      else ref_starve = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already applied at the falling edge; compare, then advance.
  task automatic step();
    #1;
    model_eval();
    o_wb0_rdy = bus.wb0_ready; o_wb1_rdy = bus.wb1_ready; o_rd_rdy = bus.rd_ready;
    o_boost = bus.starve_boost; o_cnt = 32'(bus.starve_cnt); o_rd0 = bus.rd_data_0;
    check("wb0_ready", bus.wb0_ready, e_wb0_rdy);
    check("wb1_ready", bus.wb1_ready, e_wb1_rdy);
    check("rd_ready", bus.rd_ready, e_rd_rdy);
    check("starve_boost", bus.starve_boost, e_boost);
    check("starve_cnt", bus.starve_cnt, e_cnt);
    check("rr_ptr", bus.rr_ptr, e_rr);
    check("rf_warp_selector", bus.rf_warp_selector, e_sel);
    check("rf_write_en", bus.rf_write_en, e_wen);
    check("rf_waddr", bus.rf_waddr, e_waddr);
    check("rf_wdata", bus.rf_wdata, e_wdata);
    check("rf_read_en_0", bus.rf_read_en_0, e_ren0);
    check("rf_read_en_1", bus.rf_read_en_1, e_ren1);
    check("rf_raddr_0", bus.rf_raddr_0, e_raddr0);
    check("rf_raddr_1", bus.rf_raddr_1, e_raddr1);
    if (e_rd_rdy || rst) begin
      check("rd_data_0", bus.rd_data_0, e_rd0);
      check("rd_data_1", bus.rd_data_1, e_rd1);
    end
    model_commit();
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  function automatic logic [LW-1:0] rand_data();
    logic [LW-1:0] d;
    for (int i = 0; i < LW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic clear_req();
    bus.wb0_valid = 0; bus.wb0_warp = '0; bus.wb0_addr = '0; bus.wb0_mask = '0; bus.wb0_data = '0;
    bus.wb1_valid = 0; bus.wb1_warp = '0; bus.wb1_addr = '0; bus.wb1_mask = '0; bus.wb1_data = '0;
    bus.rd_valid = 0; bus.rd_warp = '0; bus.rd_en_0 = '0; bus.rd_en_1 = '0;
    bus.rd_addr_0 = '0; bus.rd_addr_1 = '0;
  endtask

  task automatic set_wb(input int s, input logic v, input int w, input int a,
                        input logic [NUM_LANES-1:0] m, input logic [LW-1:0] d);
    if (s == 0) begin
      bus.wb0_valid = v; bus.wb0_warp = WW'(w); bus.wb0_addr = AW'(a); bus.wb0_mask = m; bus.wb0_data = d;
    end else begin
      bus.wb1_valid = v; bus.wb1_warp = WW'(w); bus.wb1_addr = AW'(a); bus.wb1_mask = m; bus.wb1_data = d;
    end
  endtask

  task automatic set_rd(input logic v, input int w, input logic [NUM_LANES-1:0] e0,
                        input logic [NUM_LANES-1:0] e1, input int a0, input int a1);
    bus.rd_valid = v; bus.rd_warp = WW'(w); bus.rd_en_0 = e0; bus.rd_en_1 = e1;
    bus.rd_addr_0 = AW'(a0); bus.rd_addr_1 = AW'(a1);
  endtask

  task automatic rand_mask(output logic [NUM_LANES-1:0] m);
    m = ($urandom_range(0, 7) == 0) ? '0 : NUM_LANES'($urandom_range(0, 255));
  endtask

  // ---------------- stimulus ----------------
  logic [LW-1:0]        d0, old_row, exp_row;
  logic [NUM_LANES-1:0] m0, m1;

  initial begin
    rst = 1'b1;
    init_mem = 1'b1;
    seed = $urandom;
    ref_rr = 0;
    ref_starve = 0;
    for (int w = 0; w < NUM_WARPS; w++)
      for (int r = 0; r < NUM_REGS; r++)
        for (int l = 0; l < NUM_LANES; l++) ref_mem[w][r][l] = seed_val(w, r, l);
    clear_req();
    @(negedge clk);
    init_mem = 1'b0;

    // Requests during reset are ignored and every output is zero.
    set_wb(0, 1, 2, 5, 8'hFF, rand_data());
    set_rd(1, 3, 8'hFF, 8'hFF, 1, 2);
    step();
    check("rst_rd_ready", o_rd_rdy, 1'b0);

    // Idle after release, then write warp 2 addr 5 and read it back.
    rst = 1'b0;
    clear_req();
    step();
    d0 = rand_data();
    set_wb(0, 1, 2, 5, 8'hFF, d0);
    step();
    check("tp_wb0_ready", o_wb0_rdy, 1'b1);
    clear_req();
    set_rd(1, 2, 8'hFF, 8'hFF, 5, 5);
    step();
    check("tp_read_back", o_rd0, d0);

    // Round-robin from reset: wb0, wb1, wb0, wb1.
    rst = 1'b1; clear_req(); step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_wb(0, 1, 3, i, 8'hFF, rand_data());
      set_wb(1, 1, 6, i, 8'hFF, rand_data());
      step();
      check("tp_rr_order", o_wb0_rdy, (i % 2) == 0);
    end

    // Same-warp write and read of warp 1 addr 3.
    clear_req();
    old_row = ref_row(1, 3);
    d0 = rand_data();
    set_wb(0, 1, 1, 3, 8'hFF, d0);
    set_rd(1, 1, 8'hFF, 8'h00, 3, 0);
    step();
    check("tp_same_both", {o_wb0_rdy, o_rd_rdy}, 2'b11);
`ifdef RF_BYPASS_EN
    check("tp_same_data", o_rd0, d0);
`else
    check("tp_same_data", o_rd0, old_row);
`endif

    // Continuous cross-warp writes: read forced through on cycle 4.
    clear_req(); step();
    set_rd(1, 4, 8'hFF, 8'hFF, 1, 2);
    for (int c = 1; c <= 4; c++) begin
      set_wb(0, 1, 0, c, 8'hFF, rand_data());
      step();
      check("tp_starve_rd", o_rd_rdy, c == 4);
      check("tp_starve_wb", o_wb0_rdy, c != 4);
      check("tp_starve_boost", o_boost, c == 4);
    end
    bus.rd_valid = 1'b0;
    step();
    check("tp_starve_clear", o_cnt, 32'd0);

    // Partial write mask against full read enables on the same address.
    clear_req();
    old_row = ref_row(5, 7);
    d0 = rand_data();
    set_wb(0, 1, 5, 7, 8'h0F, d0);
    set_rd(1, 5, 8'hFF, 8'hFF, 7, 7);
    step();
    exp_row = old_row;
`ifdef RF_BYPASS_EN
    exp_row[4*DATA_W-1:0] = d0[4*DATA_W-1:0];
`endif
    check("tp_partial_bypass", o_rd0, exp_row);

    // Reset with starve_cnt at 2 forces three fresh denials.
    clear_req();
    set_wb(0, 1, 0, 0, 8'hFF, rand_data());
    set_rd(1, 4, 8'hFF, 8'h00, 2, 0);
    step(); step();
    check("tp_pre_rst_cnt", o_cnt, 32'd1);
    rst = 1'b1; step();
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("tp_rst_starve", o_rd_rdy, c == 4);
    end

    // Randomized traffic with held requests and occasional reset.
    clear_req();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!(bus.wb0_valid && !e_wb0_rdy)) begin
        rand_mask(m0);
        set_wb(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2), $urandom_range(0, 3), m0, rand_data());
      end
      if (!(bus.wb1_valid && !e_wb1_rdy)) begin
        rand_mask(m1);
        set_wb(1, $urandom_range(0, 3) != 0, $urandom_range(0, 2), $urandom_range(0, 3), m1, rand_data());
      end
      if (!(bus.rd_valid && !e_rd_rdy)) begin
        rand_mask(m0);
        rand_mask(m1);
        set_rd($urandom_range(0, 2) != 0, $urandom_range(0, 2), m0, m1,
               $urandom_range(0, 3), $urandom_range(0, 3));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
